// File: rtl/cpu_state_sequencer.sv
// Multi-cycle state sequencer for the MIPS core: FETCH/EXEC/MEM/STALL/HALT control,
// Avalon waitrequest hold-off and one-cycle IR/PC/load commit strobes.
module cpu_state_sequencer #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       waitrequest,
    input  logic [5:0] opcode,
    input  logic [5:0] function_code,
    input  logic       pc_next_zero,
    output logic [2:0] state,
    output logic       ir_wren,
    output logic       pc_wren,
    output logic       load_wren,
    output logic       active
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_MEM   = 3'd1,
        S_EXEC  = 3'd2,
        S_STALL = 3'd3,
        S_HALT  = 3'd4
    } seq_state_e;

    localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

    seq_state_e state_r;
    seq_state_e state_next_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic       active_r;
    logic       active_next_s;
    logic       ir_s;
    logic       pc_s;
    logic       ld_s;

    function automatic logic is_load(input logic [5:0] op);
        return (op >= 6'd32) && (op <= 6'd38);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load(op) || (op == 6'd40) || (op == 6'd41) || (op == 6'd43);
    endfunction

    function automatic logic is_multdiv(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'd0) && (fn >= 6'd24) && (fn <= 6'd27);
    endfunction

    function automatic logic [7:0] stall_len(input logic [5:0] fn);
        logic [7:0] n;
        case (fn)
            6'd24, 6'd25: n = MULT_N;
            6'd26, 6'd27: n = DIV_N;
            default:      n = 8'd0;
        endcase
        return n;
    endfunction

    // Commit destination: HALT when the retiring instruction jumps to address 0.
    function automatic seq_state_e commit_target(input logic pcz);
        return pcz ? S_HALT : S_FETCH;
    endfunction

    // Next-state, counter and strobe decode from registered state plus live inputs.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        ir_s         = 1'b0;
        pc_s         = 1'b0;
        ld_s         = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (active_r && !waitrequest) begin
                    ir_s         = 1'b1;
                    state_next_s = S_EXEC;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_mem_op(opcode)) begin
                    state_next_s = S_MEM;
                end else if (is_multdiv(opcode, function_code) &&
                             (stall_len(function_code) != 8'd0)) begin
                    cnt_next_s   = stall_len(function_code);
                    state_next_s = S_STALL;
                end else begin
                    pc_s         = 1'b1;
                    state_next_s = commit_target(pc_next_zero);
                end
            end
            S_MEM: begin
                if (!waitrequest) begin
                    pc_s         = 1'b1;
                    ld_s         = is_load(opcode);
                    state_next_s = commit_target(pc_next_zero);
                end else begin
                    state_next_s = S_MEM;
                end
            end
            S_STALL: begin
                // A zero count here can only follow corruption; retire rather than wrap.
                if (cnt_r <= 8'd1) begin
                    pc_s         = 1'b1;
                    cnt_next_s   = 8'd0;
                    state_next_s = commit_target(pc_next_zero);
                end else begin
                    cnt_next_s   = cnt_r - 8'd1;
                    state_next_s = S_STALL;
                end
            end
            S_HALT: begin
                state_next_s = S_HALT;
            end
            default: begin
                state_next_s = S_FETCH;
                cnt_next_s   = 8'd0;
            end
        endcase
        if (state_next_s == S_HALT) begin
            active_next_s = 1'b0;
        end else begin
            active_next_s = 1'b1;
        end
    end

    // State, stall counter and run flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= S_FETCH;
            cnt_r    <= 8'd0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            active_r <= active_next_s;
        end
    end

    assign state     = state_r;
    assign active    = active_r;
    assign ir_wren   = ir_s & active_r;
    assign pc_wren   = pc_s & active_r;
    assign load_wren = ld_s & active_r;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Directed bench: a trace-building model turns each instruction description into its
// expected per-cycle outputs; one compare process checks every cycle at the falling edge.
module tb_cpu_state_sequencer;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 0;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       waitrequest = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] function_code = 6'd0;
    logic       pc_next_zero = 1'b0;
    logic [2:0] state;
    logic       ir_wren;
    logic       pc_wren;
    logic       load_wren;
    logic       active;

    cpu_state_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .opcode(opcode),
        .function_code(function_code), .pc_next_zero(pc_next_zero), .state(state),
        .ir_wren(ir_wren), .pc_wren(pc_wren), .load_wren(load_wren), .active(active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic       ir, pc, ld, act;
        logic [5:0] op, fn;
        logic       wr, pcz, rstn;
    } rec_t;

    rec_t plan[$];
    rec_t chk_q[$];
    rec_t e;
    int   total = 0;
    int   bad = 0;
    int   cnt_ir = 0, cnt_pc = 0, cnt_ld = 0;

    task automatic push_rec(input logic [2:0] st, input logic ir, pc, ld, act,
                            input logic [5:0] op, fn, input logic wr, pcz, rstn);
        rec_t r;
        r.st = st; r.ir = ir; r.pc = pc; r.ld = ld; r.act = act;
        r.op = op; r.fn = fn; r.wr = wr; r.pcz = pcz; r.rstn = rstn;
        plan.push_back(r);
    endtask

    // Expected trace of one instruction: fw fetch waits, mw memory waits.
    // pc_next_zero is held high in every non-commit cycle to show it is ignored there.
    task automatic plan_instr(input logic [5:0] op, fn, input int fw, mw, input logic pcz);
        bit mem = ((op >= 32) && (op <= 38)) || op == 40 || op == 41 || op == 43;
        bit ld  = (op >= 32) && (op <= 38);
        bit md  = (op == 0) && (fn >= 24) && (fn <= 27);
        int n   = (fn == 24 || fn == 25) ? MULT_N : DIV_N;
        for (int i = 0; i < fw; i++) push_rec(3'd0, 0, 0, 0, 1, op, fn, 1, 1, 1);
        push_rec(3'd0, 1, 0, 0, 1, op, fn, 0, 1, 1);
        if (mem) begin
            push_rec(3'd2, 0, 0, 0, 1, op, fn, 0, 1, 1);
            for (int i = 0; i < mw; i++) push_rec(3'd1, 0, 0, 0, 1, op, fn, 1, 1, 1);
            push_rec(3'd1, 0, 1, ld, 1, op, fn, 0, pcz, 1);
        end else if (md && n > 0) begin
            push_rec(3'd2, 0, 0, 0, 1, op, fn, 0, 1, 1);
            for (int i = 0; i < n - 1; i++) push_rec(3'd3, 0, 0, 0, 1, op, fn, 1, 1, 1);
            push_rec(3'd3, 0, 1, 0, 1, op, fn, 1, pcz, 1);
        end else begin
            push_rec(3'd2, 0, 1, 0, 1, op, fn, 0, pcz, 1);
        end
    endtask

    task automatic plan_halt(input int n);
        for (int i = 0; i < n; i++) push_rec(3'd4, 0, 0, 0, 0, 6'd0, 6'd0, 0, 0, 1);
    endtask

    // Reset held n cycles (waitrequest low would fetch if not blocked), then one idle cycle.
    task automatic plan_reset(input int n);
        for (int i = 0; i < n; i++) push_rec(3'd0, 0, 0, 0, 0, 6'd0, 6'd0, 0, 1, 0);
        push_rec(3'd0, 0, 0, 0, 0, 6'd0, 6'd0, 0, 0, 1);
    endtask

    task automatic truncate_plan(input int k);
        while (plan.size() > k) void'(plan.pop_back());
    endtask

    function automatic logic [23:0] plan_states();
        logic [23:0] v = 24'd0;
        foreach (plan[i]) v = {v[20:0], plan[i].st};
        return v;
    endfunction

    task automatic run_plan();
        rec_t r;
        while (plan.size() > 0) begin
            r = plan.pop_front();
            @(posedge clk);
            #1;
            reset_n       = r.rstn;
            waitrequest   = r.wr;
            opcode        = r.op;
            function_code = r.fn;
            pc_next_zero  = r.pcz;
            chk_q.push_back(r);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act_v, input int exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act_v, exp_v);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the planned trace.
    always @(negedge clk) begin
        if (chk_q.size() != 0) begin
            e = chk_q.pop_front();
            total++;
            if (state !== e.st || ir_wren !== e.ir || pc_wren !== e.pc ||
                load_wren !== e.ld || active !== e.act) begin
                bad++;
                $display("FAIL cycle@%0t: state=%0d ir=%b pc=%b ld=%b act=%b required state=%0d ir=%b pc=%b ld=%b act=%b",
                         $time, state, ir_wren, pc_wren, load_wren, active,
                         e.st, e.ir, e.pc, e.ld, e.act);
            end
        end
        cnt_ir += int'(ir_wren);
        cnt_pc += int'(pc_wren);
        cnt_ld += int'(load_wren);
    end

    initial begin
        int s_ir, s_pc, s_ld;
        #2;
        check("reset_state", int'(state), 0);
        check("reset_active", int'(active), 0);

        // 1: reset 3 cycles, then ADDU
        plan_reset(3);
        run_plan();
        plan_instr(6'd0, 6'd33, 0, 0, 1'b0);
        check("model_addu_len", plan.size(), 2);
        check("model_addu_states", int'(plan_states()), int'(24'o02));
        run_plan();

        // 2: LW with 2 fetch waits and 3 memory waits
        plan_instr(6'd35, 6'd0, 2, 3, 1'b0);
        check("model_lw_len", plan.size(), 8);
        check("model_lw_states", int'(plan_states()), int'(24'o00021111));
        s_ir = cnt_ir; s_pc = cnt_pc; s_ld = cnt_ld;
        run_plan();
        check("lw_ir_count", cnt_ir - s_ir, 1);
        check("lw_pc_count", cnt_pc - s_pc, 1);
        check("lw_ld_count", cnt_ld - s_ld, 1);

        // 3: stores and other loads
        s_pc = cnt_pc; s_ld = cnt_ld;
        plan_instr(6'd43, 6'd0, 0, 1, 1'b0);
        run_plan();
        check("sw_pc_count", cnt_pc - s_pc, 1);
        check("sw_ld_count", cnt_ld - s_ld, 0);
        plan_instr(6'd40, 6'd0, 1, 0, 1'b0);
        plan_instr(6'd32, 6'd0, 0, 0, 1'b0);
        plan_instr(6'd38, 6'd0, 0, 2, 1'b0);
        plan_instr(6'd41, 6'd0, 0, 0, 1'b0);
        run_plan();

        // 4: multiply stalls, divide with zero extra cycles, branch
        plan_instr(6'd0, 6'd24, 0, 0, 1'b0);
        check("model_mult_len", plan.size(), 6);
        check("model_mult_states", int'(plan_states()), int'(24'o023333));
        s_pc = cnt_pc;
        run_plan();
        check("mult_pc_count", cnt_pc - s_pc, 1);
        plan_instr(6'd0, 6'd25, 1, 0, 1'b0);
        plan_instr(6'd0, 6'd26, 0, 0, 1'b0);
        plan_instr(6'd0, 6'd27, 0, 0, 1'b0);
        plan_instr(6'd4, 6'd0, 0, 0, 1'b0);
        run_plan();

        // 6: reset mid-MEM and mid-STALL, then clean restart
        plan_instr(6'd35, 6'd0, 0, 3, 1'b0);
        truncate_plan(3);
        plan_reset(2);
        plan_instr(6'd0, 6'd24, 0, 0, 1'b0);
        truncate_plan(plan.size() - 2);
        plan_reset(2);
        plan_instr(6'd0, 6'd33, 0, 0, 1'b0);
        run_plan();

        // 5: JR to zero halts the core
        s_ir = cnt_ir;
        plan_instr(6'd0, 6'd8, 0, 0, 1'b1);
        plan_halt(20);
        run_plan();
        check("halt_ir_count", cnt_ir - s_ir, 1);
        check("halt_active", int'(active), 0);

        // Halt from the final STALL cycle of a multiply
        plan_reset(1);
        plan_instr(6'd0, 6'd25, 0, 0, 1'b1);
        plan_halt(3);
        run_plan();
        check("halt_state", int'(state), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
